task_batcher: RTL and testbench
===============================

// Module: task_batcher
// PURPOSE
//  Upstream feeder for the load balancer. Accepts single task requests (valid/ready), counts them
//  as pending, and periodically emits them as an 8-bit thermometer task mask (tasks[7:0]). Batch size
//  shrinks while the balancer asserts trigger; emission stalls while it asserts overload.
//  tasks is 8'h00 on every cycle with no emission, since the balancer samples tasks every clock.
// PARAMETERS
//  DEPTH         16  max pending tasks held; req_ready deasserts at this level (1..255)
//  BATCH_MAX      8  max set bits per mask, normal mode (1..8)
//  THROTTLE_MAX   2  max set bits per mask while trigger=1 (1..BATCH_MAX)
//  WINDOW         4  collect cycles before a partial batch is emitted (>=1)
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  synchronous, active-high reset
//  req_valid    in   1  one task request offered this cycle
//  req_ready    out  1  request accepted when req_valid & req_ready
//  trigger      in   1  balancer trigger (some server count >= 3): throttle batch size
//  overload     in   1  balancer overload (all server counts >= 3): hold emission
//  tasks        out  8  thermometer mask of n tasks, bits [n-1:0] set, bit 0 first
//  tasks_valid  out  1  one-cycle pulse, high exactly when tasks != 0
//  pending      out  PW pending task count, PW = $clog2(DEPTH+1)
//  batches      out  8  emitted-batch counter, wraps 255->0
// BEHAVIOUR
//  Reset: state=IDLE; pending=0; tasks=8'h00; tasks_valid=0; batches=0; window cnt=0.
//   Reset mid-operation discards all pending tasks, and any pulse in flight drops next cycle.
//  req_ready = (pending < DEPTH), from registered pending. The same-cycle emit is not credited.
//  accept = req_valid & req_ready; pending_next = pending + accept - n_emit (both may occur).
//  limit = trigger ? THROTTLE_MAX : BATCH_MAX, sampled on the decision cycle; n = min(pending, limit).
//  FSM:
//   IDLE    : pending==0. On accept -> COLLECT, wcnt=0.
//   COLLECT : wcnt++ per cycle. Fire when pending>=limit or wcnt==WINDOW-1:
//             overload=0 -> EMIT at the next edge; overload=1 -> STALL.
//   STALL   : no emission, tasks=0, requests still accepted up to DEPTH. overload=0 -> EMIT.
//   EMIT    : the registered outputs for this cycle are tasks=mask(n), tasks_valid=1, and batches is
//             incremented. pending drops by n at the entering edge. Exit: pending_next>0 -> COLLECT
//             (wcnt=0), else IDLE. overload or trigger rising during EMIT does not alter the pulse.
//  Latency: the first request into an empty block appears on tasks no earlier than 2 cycles after
//   acceptance, and no later than WINDOW+1 cycles after it (overload permitting).
//  Back-to-back: minimum spacing between pulses is 2 cycles (EMIT->COLLECT->EMIT).
//  Boundaries:
//   - pending==DEPTH: req_ready=0, and it reasserts the cycle after an emission lowers pending.
//   - A stall never drops tasks. DEPTH bounds pending, so no overflow.
//   - n>=1 is guaranteed, because pending>=1 in COLLECT/STALL.
//   - batches wraps silently.
// STRUCTURE
//  Shared package lb_pkg: localparam TASK_W=8, the batcher state enum (IDLE, COLLECT, STALL, EMIT),
//   and the overload/trigger threshold constant 4'd3, shared with the balancer.
//  One sub-module: task_mask_gen, a combinational count -> thermometer mask (n -> (1<<n)-1, TASK_W wide).
// TESTING
//  1) reset; 3 requests on back-to-back cycles, trigger=0, overload=0
//     -> one pulse tasks=8'h07 by WINDOW expiry; pending back to 0; batches=1.
//  2) 10 requests, trigger=0 -> pulse tasks=8'hFF, then a later pulse tasks=8'h03; never 9+ bits.
//  3) trigger=1 held, 5 requests -> pulses 8'h03, 8'h03, 8'h01; pulses >=2 cycles apart.
//  4) overload=1 with 4 pending -> tasks=0 throughout the stall, requests still accepted;
//     drop overload -> next cycle tasks=mask(min(pending,8)).
//  5) req_valid held high, overload=1 -> pending saturates at 16, req_ready=0;
//     clear overload -> pulse 8'hFF, then req_ready=1.
//  6) reset asserted mid-STALL with pending=6 -> next cycle pending=0, tasks=0, state IDLE; no pulse.

Source files
------------

// File: rtl/lb_pkg.sv
// lb_pkg: definitions shared by the task batcher and the load balancer.
//   TASK_W         width of the task mask handed to the balancer
//   batch_state_e  batcher control states
//   LB_THRESH      per-server count at which trigger/overload are raised
package lb_pkg;

   localparam int unsigned TASK_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      STALL,
      EMIT
   } batch_state_e;

   localparam logic [3:0] LB_THRESH = 4'd3;

endpackage

// File: rtl/task_mask_gen.sv
// task_mask_gen: combinational count -> thermometer mask, mask = (1 << n) - 1.
//   count_i  in   CW      number of low bits to set (0..TASK_W)
//   mask_o   out  TASK_W  bits [count_i-1:0] set, the rest clear
module task_mask_gen
   import lb_pkg::*;
#(
   parameter int unsigned CW = $clog2(TASK_W + 1)
) (
   input  logic [CW-1:0]     count_i,
   output logic [TASK_W-1:0] mask_o
);

   always_comb begin
      mask_o = '0;
      for (int unsigned i = 0; i < TASK_W; i++) begin
         if (i < 32'(count_i)) mask_o[i] = 1'b1;
      end
   end

endmodule

// File: rtl/task_batcher.sv
// task_batcher: accepts single task requests, holds them as a pending count and
// emits them to the load balancer as a thermometer mask. The batch size shrinks
// while trigger is high; emission is held while overload is high.
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous active-high reset
//   req_valid    in   1       task request offered
//   req_ready    out  1       request accepted when req_valid & req_ready
//   trigger      in   1       throttle batch size to THROTTLE_MAX
//   overload     in   1       hold emission
//   tasks        out  TASK_W  thermometer mask of emitted tasks, 0 when idle
//   tasks_valid  out  1       high exactly when tasks != 0
//   pending      out  PW      tasks held but not yet emitted
//   batches      out  8       emitted-batch counter, wraps
module task_batcher
   import lb_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned BATCH_MAX    = 8,
   parameter int unsigned THROTTLE_MAX = 2,
   parameter int unsigned WINDOW       = 4,
   parameter int unsigned PW           = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              trigger,
   input  logic              overload,
   output logic [TASK_W-1:0] tasks,
   output logic              tasks_valid,
   output logic [PW-1:0]     pending,
   output logic [7:0]        batches
);

   localparam int unsigned CW  = $clog2(TASK_W + 1);
   localparam int unsigned MW  = (PW > CW) ? PW : CW;
   localparam int unsigned WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   batch_state_e      state_q, state_d;
   logic [PW-1:0]     pending_q, pending_d;
   logic [WCW-1:0]    wcnt_q, wcnt_d;
   logic [TASK_W-1:0] tasks_q;
   logic              tv_q;
   logic [7:0]        batches_q;

   logic              accept;
   logic              fire;
   logic              full_batch;
   logic [CW-1:0]     limit;
   logic [CW-1:0]     n_avail;
   logic [CW-1:0]     n_emit;
   logic [TASK_W-1:0] mask;

   assign req_ready   = (pending_q < PW'(DEPTH));
   assign tasks       = tasks_q;
   assign tasks_valid = tv_q;
   assign pending     = pending_q;
   assign batches     = batches_q;

   task_mask_gen #(.CW(CW)) u_mask (
      .count_i (n_emit),
      .mask_o  (mask)
   );

   always_comb begin
      accept     = req_valid & req_ready;
      limit      = trigger ? CW'(THROTTLE_MAX) : CW'(BATCH_MAX);
      // Compare at a common width so tiny DEPTH values cannot truncate the limit.
      full_batch = (MW'(pending_q) >= MW'(limit));
      n_avail    = full_batch ? limit : CW'(pending_q);
      fire       = full_batch || (wcnt_q == WCW'(WINDOW - 1));

      state_d = state_q;
      wcnt_d  = wcnt_q;
      n_emit  = '0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = COLLECT;
               wcnt_d  = '0;
            end
         end
         COLLECT: begin
            if (fire) begin
               if (overload) begin
                  state_d = STALL;
               end else begin
                  state_d = EMIT;
                  n_emit  = n_avail;
               end
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         STALL: begin
            if (!overload) begin
               state_d = EMIT;
               n_emit  = n_avail;
            end
         end
         EMIT: begin
            // The pulse is already registered; only the follow-on state is decided here.
            state_d = ((pending_q != '0) || accept) ? COLLECT : IDLE;
            wcnt_d  = '0;
         end
      endcase

      pending_d = pending_q + PW'(accept) - PW'(n_emit);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         wcnt_q    <= '0;
         tasks_q   <= '0;
         tv_q      <= 1'b0;
         batches_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         wcnt_q    <= wcnt_d;
         tasks_q   <= mask;
         tv_q      <= (n_emit != '0);
         if (n_emit != '0) batches_q <= batches_q + 8'd1;
      end
   end

endmodule

// File: tb/tb_task_batcher.sv
module tb_task_batcher;

   localparam int DEPTH        = 16;
   localparam int BATCH_MAX    = 8;
   localparam int THROTTLE_MAX = 2;
   localparam int WINDOW       = 4;
   localparam int PW           = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          trigger;
   logic          overload;
   logic [7:0]    tasks;
   logic          tasks_valid;
   logic [PW-1:0] pending;
   logic [7:0]    batches;

   always #5 clk = ~clk;

   task_batcher #(
      .DEPTH        (DEPTH),
      .BATCH_MAX    (BATCH_MAX),
      .THROTTLE_MAX (THROTTLE_MAX),
      .WINDOW       (WINDOW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .trigger     (trigger),
      .overload    (overload),
      .tasks       (tasks),
      .tasks_valid (tasks_valid),
      .pending     (pending),
      .batches     (batches)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tasks are a plain count. A batch becomes "due" once enough
   // tasks are waiting or the collection age hits the window; a due batch leaves
   // on the first edge without overload, and the cycle showing a pulse never
   // starts another.
   int   m_pend = 0;
   int   m_age = -1;        // cycles spent collecting, -1 when nothing is collecting
   bit   m_due = 0;
   bit   m_showing = 0;     // the pulse is on the outputs this cycle
   int   m_tasks = 0;
   int   m_batches = 0;
   bit   m_started = 0;
   int   pulse_log[$];

   task automatic model_step();
      int acc, lim, n;
      if (reset) begin
         m_pend = 0; m_age = -1; m_due = 0; m_showing = 0;
         m_tasks = 0; m_batches = 0; m_started = 1;
         return;
      end
      acc = (req_valid && m_pend < DEPTH) ? 1 : 0;
      lim = trigger ? THROTTLE_MAX : BATCH_MAX;
      n = 0;
      if (m_showing) begin
         m_showing = 0;
         m_age = (m_pend + acc > 0) ? 0 : -1;
      end else if (m_age < 0) begin
         if (acc == 1) m_age = 0;
      end else begin
         if (m_pend >= lim || m_age == WINDOW - 1) m_due = 1;
         if (m_due && !overload) begin
            n = (m_pend < lim) ? m_pend : lim;
            m_due = 0;
            m_showing = 1;
         end else if (!m_due) begin
            m_age++;
         end
      end
      m_pend = m_pend + acc - n;
      m_tasks = (1 << n) - 1;
      if (n > 0) begin
         m_batches = (m_batches + 1) % 256;
         pulse_log.push_back(m_tasks);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   int since_pulse = 100;

   always @(negedge clk) begin
      if (m_started) begin
         chk("tasks", 32'(tasks), 32'(m_tasks));
         chk("tasks_valid", 32'(tasks_valid), 32'(m_tasks != 0));
         chk("pending", 32'(pending), 32'(m_pend));
         chk("req_ready", 32'(req_ready), 32'(m_pend < DEPTH));
         chk("batches", 32'(batches), 32'(m_batches));
         if (tasks_valid) begin
            chk("pulse_gap", 32'(since_pulse >= 1), 32'd1);
            since_pulse = 0;
         end else begin
            since_pulse++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int log_at(input int idx);
      if (idx < pulse_log.size()) return pulse_log[idx];
      return 32'hFFFF;
   endfunction

   initial begin
      reset = 1'b1; req_valid = 1'b0; trigger = 1'b0; overload = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      step();
      chk("rst_tasks", 32'(tasks), 32'h0);
      chk("rst_valid", 32'(tasks_valid), 32'h0);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_batches", 32'(batches), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h1);

      // 1) three requests -> single 8'h07 pulse
      pulse_log.delete();
      req_valid = 1'b1; repeat (3) step();
      req_valid = 1'b0; repeat (8) step();
      chk("t1_npulses", pulse_log.size(), 1);
      chk("t1_mask", log_at(0), 32'h07);
      chk("t1_pending", 32'(pending), 32'h0);
      chk("t1_batches", 32'(batches), 32'h1);

      // 2) ten requests collected under overload -> 8'hFF then 8'h03
      pulse_log.delete();
      overload = 1'b1; req_valid = 1'b1; repeat (10) step();
      req_valid = 1'b0; step();
      overload = 1'b0; repeat (10) step();
      chk("t2_npulses", pulse_log.size(), 2);
      chk("t2_mask0", log_at(0), 32'hFF);
      chk("t2_mask1", log_at(1), 32'h03);
      chk("t2_batches", 32'(batches), 32'h3);

      // 3) throttled: five requests -> 03, 03, 01
      pulse_log.delete();
      trigger = 1'b1; req_valid = 1'b1; repeat (5) step();
      req_valid = 1'b0; repeat (10) step();
      trigger = 1'b0;
      chk("t3_npulses", pulse_log.size(), 3);
      chk("t3_mask0", log_at(0), 32'h03);
      chk("t3_mask1", log_at(1), 32'h03);
      chk("t3_mask2", log_at(2), 32'h01);

      // 4) stall holds tasks and keeps accepting; release emits all six
      pulse_log.delete();
      overload = 1'b1; req_valid = 1'b1; repeat (4) step();
      req_valid = 1'b0; repeat (4) step();
      req_valid = 1'b1; repeat (2) step();
      req_valid = 1'b0; repeat (3) step();
      chk("t4_stall_pending", 32'(pending), 32'd6);
      chk("t4_stall_tasks", 32'(tasks), 32'h0);
      chk("t4_stall_npulses", pulse_log.size(), 0);
      overload = 1'b0; step();
      chk("t4_release_tasks", 32'(tasks), 32'h3F);
      repeat (8) step();
      chk("t4_npulses", pulse_log.size(), 1);
      chk("t4_mask", log_at(0), 32'h3F);

      // 5) saturate at DEPTH, then release
      pulse_log.delete();
      overload = 1'b1; req_valid = 1'b1; repeat (22) step();
      chk("t5_full_pending", 32'(pending), 32'd16);
      chk("t5_full_ready", 32'(req_ready), 32'h0);
      overload = 1'b0; req_valid = 1'b0; step();
      chk("t5_release_tasks", 32'(tasks), 32'hFF);
      chk("t5_release_pending", 32'(pending), 32'd8);
      chk("t5_ready_back", 32'(req_ready), 32'h1);
      repeat (10) step();
      chk("t5_mask0", log_at(0), 32'hFF);
      chk("t5_drained", 32'(pending), 32'h0);

      // 6) reset in the middle of a stall
      overload = 1'b1; req_valid = 1'b1; repeat (6) step();
      req_valid = 1'b0; repeat (4) step();
      chk("t6_stall_pending", 32'(pending), 32'd6);
      pulse_log.delete();
      reset = 1'b1; step();
      reset = 1'b0; overload = 1'b0;
      chk("t6_pending", 32'(pending), 32'h0);
      chk("t6_tasks", 32'(tasks), 32'h0);
      chk("t6_batches", 32'(batches), 32'h0);
      repeat (6) step();
      chk("t6_npulses", pulse_log.size(), 0);

      // Randomized traffic against the model
      pulse_log.delete();
      for (int i = 0; i < 3000; i++) begin
         req_valid = ($urandom_range(0, 9) < 7);
         trigger   = ($urandom_range(0, 9) < 3);
         overload  = ($urandom_range(0, 9) < 2);
         reset     = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0; req_valid = 1'b0; overload = 1'b0; trigger = 1'b0;
      repeat (20) step();
      chk("rand_drained", 32'(pending), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
